// File: rtl/expr_ctrl_pkg.sv
// Shared definitions for the expression sweep controller: state encoding,
// default sizing and the golden Expr04 truth table.
package expr_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int N_IN_DEF   = 3;
   localparam int SETTLE_DEF = 1;

   // f = a & ~(b & c) is high only for vec 4, 5 and 6
   localparam logic [7:0] EXPR04_TT = 8'h70;

endpackage

// File: rtl/expr_settle_timer.sv
// Per-vector settle counter: clears to zero, counts up on request and flags
// the cycle in which the configured settle count has been reached.
module expr_settle_timer #(
   parameter logic [3:0] LIMIT = 4'd1
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_term
);

   logic [3:0] r_cnt;

   // Counter register; clear has priority over increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= 4'd0;
      end else if (i_clr) begin
         r_cnt <= 4'd0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + 4'd1;
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_term = (r_cnt == LIMIT);

endmodule

// File: rtl/expr_sweep_ctrl.sv
// Exhaustive truth-table sweeper: drives every input vector, samples the
// reference and checked outputs after a settle delay and reports pass/fail.
module expr_sweep_ctrl
   import expr_ctrl_pkg::*;
#(
   parameter int N_IN   = N_IN_DEF,
   parameter int SETTLE = SETTLE_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      vec,
   input  logic                 f_ref,
   input  logic                 f_dut,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]   table_ref,
   output logic [2**N_IN-1:0]   table_dut,
   output logic [2**N_IN-1:0]   mismatch,
   output logic                 pass
);

   localparam int              NV       = 2**N_IN;
   localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

   state_t            r_state;
   state_t            w_state;
   logic [N_IN-1:0]   r_vec;
   logic [N_IN-1:0]   w_vec;
   logic              r_busy;
   logic              w_busy;
   logic              r_done;
   logic              w_done;
   logic              r_pass;
   logic              w_pass;
   logic [NV-1:0]     r_tref;
   logic [NV-1:0]     w_tref;
   logic [NV-1:0]     r_tdut;
   logic [NV-1:0]     w_tdut;
   logic              w_clr;
   logic              w_inc;
   logic              w_term;

   expr_settle_timer #(
      .LIMIT (SETTLE[3:0])
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_inc  (w_inc),
      .o_term (w_term)
   );

   // State and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_vec   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_tref  <= '0;
         r_tdut  <= '0;
      end else begin
         r_state <= w_state;
         r_vec   <= w_vec;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_tref  <= w_tref;
         r_tdut  <= w_tdut;
      end
   end

   // Next-state and next-result logic for the sweep sequencer.
   always_comb begin
      w_state = r_state;
      w_vec   = r_vec;
      w_busy  = r_busy;
      w_done  = 1'b0;
      w_pass  = r_pass;
      w_tref  = r_tref;
      w_tdut  = r_tdut;
      w_clr   = 1'b0;
      w_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_state = RUN;
               w_vec   = '0;
               w_clr   = 1'b1;
               w_tref  = '0;
               w_tdut  = '0;
               w_busy  = 1'b1;
               w_pass  = 1'b0;
            end else begin
               w_state = IDLE;
            end
         end
         RUN: begin
            if (!w_term) begin
               w_inc = 1'b1;
            end else begin
               w_clr         = 1'b1;
               w_tref[r_vec] = f_ref;
               w_tdut[r_vec] = f_dut;
               // pass is resolved from the final tables so it is valid with done
               if (r_vec == VEC_LAST) begin
                  w_state = DONE;
                  w_busy  = 1'b0;
                  w_done  = 1'b1;
                  w_pass  = ((w_tref ^ w_tdut) == '0);
               end else begin
                  w_vec = r_vec + N_IN'(1);
               end
            end
         end
         DONE: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
            w_busy  = 1'b0;
         end
      endcase
   end

   assign vec       = r_vec;
   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign table_ref = r_tref;
   assign table_dut = r_tdut;
   assign mismatch  = r_tref ^ r_tdut;

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// Scoreboard bench for expr_sweep_ctrl: three instances (SETTLE=1, 0, 2)
// driven by simple expression models, checked by a negedge monitor.
module tb_expr_sweep_ctrl;
   import expr_ctrl_pkg::*;

   typedef struct {
      int         inst;
      int         cyc;
      logic [7:0] tref;
      logic [7:0] tdut;
      logic [7:0] mis;
      logic       pass;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] start_s;
   logic [2:0] f_ref_s;
   logic [2:0] f_dut_s;
   logic [2:0] busy_s;
   logic [2:0] done_s;
   logic [2:0] pass_s;
   logic [2:0] vec_s  [3];
   logic [7:0] tref_s [3];
   logic [7:0] tdut_s [3];
   logic [7:0] mis_s  [3];
   int         mode_s [3];
   logic       glitch_s;

   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   gl_base = 0;
   int   rst_chk_cyc = -1;
   int   busy_k = 0;
   int   busy_lo = -1;
   int   busy_hi = -2;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic gold(input logic [2:0] v);
      return v[2] & ~(v[1] & v[0]);
   endfunction

   function automatic logic dut_f(input int m, input logic [2:0] v, input logic gl);
      case (m)
         0:       return gold(v);
         1:       return ~v[2] & v[1] & v[0];
         2:       return 1'b1;
         3:       return gold(v) ^ gl;
         default: return 1'b0;
      endcase
   endfunction

   function automatic int settle_of(input int k);
      case (k)
         0:       return 1;
         1:       return 0;
         default: return 2;
      endcase
   endfunction

   // Inverted outside the SETTLE=2 sample cycles only
   assign glitch_s = ((cyc - gl_base) % 3) != 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int S = (g == 0) ? 1 : ((g == 1) ? 0 : 2);
      expr_sweep_ctrl #(.N_IN(3), .SETTLE(S)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .start     (start_s[g]),
         .vec       (vec_s[g]),
         .f_ref     (f_ref_s[g]),
         .f_dut     (f_dut_s[g]),
         .busy      (busy_s[g]),
         .done      (done_s[g]),
         .table_ref (tref_s[g]),
         .table_dut (tdut_s[g]),
         .mismatch  (mis_s[g]),
         .pass      (pass_s[g])
      );
      assign f_ref_s[g] = gold(vec_s[g]);
      assign f_dut_s[g] = dut_f(mode_s[g], vec_s[g], glitch_s);
   end

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, k, cyc, act, exp);
      end
   endtask

   // Monitor: reset-state checks, busy window, and scoreboard on done.
   always @(negedge clk) begin
      exp_t e;
      if (cyc == rst_chk_cyc) begin
         for (int k = 0; k < 3; k++) begin
            chk("rst_vec",  k, 32'(vec_s[k]),  32'd0);
            chk("rst_busy", k, 32'(busy_s[k]), 32'd0);
            chk("rst_done", k, 32'(done_s[k]), 32'd0);
            chk("rst_tref", k, 32'(tref_s[k]), 32'd0);
            chk("rst_tdut", k, 32'(tdut_s[k]), 32'd0);
            chk("rst_mis",  k, 32'(mis_s[k]),  32'd0);
            chk("rst_pass", k, 32'(pass_s[k]), 32'd0);
         end
      end
      if (cyc >= busy_lo && cyc <= busy_hi) begin
         chk("busy_run", busy_k, 32'(busy_s[busy_k]), 32'd1);
      end
      for (int k = 0; k < 3; k++) begin
         if (done_s[k]) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done inst=%0d cyc=%0d got=1 expected=0", k, cyc);
            end else begin
               e = sb_q.pop_front();
               chk("done_inst", k, 32'(k),         32'(e.inst));
               chk("done_cyc",  k, 32'(cyc),       32'(e.cyc));
               chk("table_ref", k, 32'(tref_s[k]), 32'(e.tref));
               chk("table_dut", k, 32'(tdut_s[k]), 32'(e.tdut));
               chk("mismatch",  k, 32'(mis_s[k]),  32'(e.mis));
               chk("pass",      k, 32'(pass_s[k]), 32'(e.pass));
               chk("busy_done", k, 32'(busy_s[k]), 32'd0);
            end
         end
      end
      if (sb_q.size() != 0 && cyc > sb_q[0].cyc) begin
         e = sb_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_done inst=%0d cyc=%0d got=0 expected=1", e.inst, cyc);
      end
   end

   task automatic push_exp(input int k, input int dcyc, input logic [7:0] tdut,
                           input logic [7:0] mis, input logic ps);
      exp_t e;
      e.inst = k;
      e.cyc  = dcyc;
      e.tref = EXPR04_TT;
      e.tdut = tdut;
      e.mis  = mis;
      e.pass = ps;
      sb_q.push_back(e);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 200; i++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
   endtask

   // One sweep: done is expected at the negedge after the last sample edge.
   task automatic sweep(input int k, input logic [7:0] tdut, input logic [7:0] mis, input logic ps);
      int len;
      len = 8 * (settle_of(k) + 1);
      @(negedge clk);
      start_s[k] = 1'b1;
      gl_base    = cyc;
      busy_k     = k;
      busy_lo    = cyc + 1;
      busy_hi    = cyc + len;
      push_exp(k, cyc + 1 + len, tdut, mis, ps);
      @(negedge clk);
      start_s[k] = 1'b0;
      wait_empty();
   endtask

   initial begin
      int s;
      rst       = 1'b1;
      start_s   = 3'b000;
      mode_s[0] = 0;
      mode_s[1] = 0;
      mode_s[2] = 0;
      repeat (3) @(negedge clk);
      rst_chk_cyc = cyc + 1;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Golden vs golden, faulty ~a&b&c, then stuck-at-1 with SETTLE=0
      sweep(0, 8'h70, 8'h00, 1'b1);
      mode_s[0] = 1;
      sweep(0, 8'h08, 8'h78, 1'b0);
      mode_s[1] = 2;
      sweep(1, 8'hFF, 8'h8F, 1'b0);

      // start held high: second sweep only after DONE -> IDLE
      mode_s[0] = 0;
      @(negedge clk);
      s = cyc;
      start_s[0] = 1'b1;
      push_exp(0, s + 17, 8'h70, 8'h00, 1'b1);
      push_exp(0, s + 35, 8'h70, 8'h00, 1'b1);
      while (cyc < s + 20) @(negedge clk);
      start_s[0] = 1'b0;
      wait_empty();

      // Reset at edge 6 of a stuck-at-1 sweep, then a clean sweep
      mode_s[0] = 2;
      @(negedge clk);
      s = cyc;
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      while (cyc < s + 6) @(negedge clk);
      rst = 1'b1;
      rst_chk_cyc = s + 7;
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      mode_s[0] = 0;
      sweep(0, 8'h70, 8'h00, 1'b1);

      // f_dut glitches only between sample edges
      mode_s[2] = 3;
      sweep(2, 8'h70, 8'h00, 1'b1);

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
